// File: rtl/giro_pos_counter.sv
// Position counter fed by rotation-decoder step pulses, with activity timer and 7-segment hex output.
// Optional macro GIRO_POS_SATURATE_EN: clamp count at the range ends instead of wrapping.
module giro_pos_counter #(
    parameter int WIDTH       = 4,
    parameter int IDLE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             step_cw,
    input  logic             step_ccw,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic             active,
    output logic [6:0]       seg
);

    localparam int TW = $clog2(IDLE_CYCLES);
    localparam logic [TW-1:0]    TIMER_LOAD = TW'(IDLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_reg, state_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             wrap_reg, wrap_next;
    logic             err_reg, err_next;
    logic [6:0]       seg_reg, seg_next;
    logic             step_ok;

    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        state_next = state_reg;
        timer_next = timer_reg;
        step_ok    = 1'b0;

        if (ena) begin
            if (step_cw && step_ccw) begin
                err_next = 1'b1;
            end else if (step_cw) begin
                step_ok  = 1'b1;
                dir_next = 1'b1;
                if (count_reg == COUNT_MAX) begin
                    wrap_next = 1'b1;
`ifdef GIRO_POS_SATURATE_EN
                    count_next = count_reg;
`else
                    count_next = '0;
`endif
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end else if (step_ccw) begin
                step_ok  = 1'b1;
                dir_next = 1'b0;
                if (count_reg == '0) begin
                    wrap_next = 1'b1;
`ifdef GIRO_POS_SATURATE_EN
                    count_next = count_reg;
`else
                    count_next = COUNT_MAX;
`endif
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end

            // Timer only advances on enabled cycles, so ena low stretches the window.
            case (state_reg)
                IDLE: begin
                    if (step_ok) begin
                        state_next = ACTIVE;
                        timer_next = TIMER_LOAD;
                    end
                end
                ACTIVE: begin
                    if (step_ok) begin
                        timer_next = TIMER_LOAD;
                    end else if (timer_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        timer_next = timer_reg - TW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        seg_next = 7'b0000000;
        case (count_reg[3:0])
            4'h0: seg_next = 7'b0111111;
            4'h1: seg_next = 7'b0000110;
            4'h2: seg_next = 7'b1011011;
            4'h3: seg_next = 7'b1001111;
            4'h4: seg_next = 7'b1100110;
            4'h5: seg_next = 7'b1101101;
            4'h6: seg_next = 7'b1111101;
            4'h7: seg_next = 7'b0000111;
            4'h8: seg_next = 7'b1111111;
            4'h9: seg_next = 7'b1101111;
            4'hA: seg_next = 7'b1110111;
            4'hB: seg_next = 7'b1111100;
            4'hC: seg_next = 7'b0111001;
            4'hD: seg_next = 7'b1011110;
            4'hE: seg_next = 7'b1111001;
            4'hF: seg_next = 7'b1110001;
            default: seg_next = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            wrap_reg  <= 1'b0;
            err_reg   <= 1'b0;
            seg_reg   <= 7'b0111111;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            wrap_reg  <= wrap_next;
            err_reg   <= err_next;
            // seg is a one-stage pipeline of count, so it always tracks the held value.
            seg_reg   <= seg_next;
        end
    end

    assign count      = count_reg;
    assign dir        = dir_reg;
    assign wrap_pulse = wrap_reg;
    assign err_pulse  = err_reg;
    assign active     = (state_reg == ACTIVE);
    assign seg        = seg_reg;

endmodule

// File: tb/tb_giro_pos_counter.sv
// Directed bench for giro_pos_counter (WIDTH=4, IDLE_CYCLES=8, default wrap build).
module tb_giro_pos_counter;

    logic       clk = 1'b0;
    logic       rst, ena, step_cw, step_ccw;
    logic [3:0] count;
    logic       dir, wrap_pulse, err_pulse, active;
    logic [6:0] seg;

    int tests  = 0;
    int failed = 0;

    giro_pos_counter #(.WIDTH(4), .IDLE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .step_cw(step_cw), .step_ccw(step_ccw),
        .count(count), .dir(dir), .wrap_pulse(wrap_pulse), .err_pulse(err_pulse),
        .active(active), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ena, cw, ccw;
        logic [3:0] count;
        logic       dir, wrap, err, act;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs, take one edge, settle to 1 ns after it.
    task automatic cyc(input logic r, input logic e, input logic cw, input logic ccw);
        rst = r; ena = e; step_cw = cw; step_ccw = ccw;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        //          rst   ena   cw    ccw   cnt    dir   wrap  err   act   seg
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0111111};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0111111};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0111111};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0111111};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000110};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000110};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1011011};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1001111};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1001111};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1011011};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000110};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0111111};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1110001};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1110001};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0111111};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0111111};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0111111};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0111111};

        rst = 1'b1; ena = 1'b0; step_cw = 1'b0; step_ccw = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].rst, vecs[i].ena, vecs[i].cw, vecs[i].ccw);
            chk($sformatf("v%0d count", i), int'(count), int'(vecs[i].count));
            chk($sformatf("v%0d dir", i), int'(dir), int'(vecs[i].dir));
            chk($sformatf("v%0d wrap", i), int'(wrap_pulse), int'(vecs[i].wrap));
            chk($sformatf("v%0d err", i), int'(err_pulse), int'(vecs[i].err));
            chk($sformatf("v%0d active", i), int'(active), int'(vecs[i].act));
            chk($sformatf("v%0d seg", i), int'(seg), int'(vecs[i].seg));
        end

        // Three cw pulses spaced 5 cycles apart; wrap never fires.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk("spaced wrap", int'(wrap_pulse), 0);
            for (int k = 0; k < 4; k++) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0);
                chk("spaced wrap idle", int'(wrap_pulse), 0);
            end
        end
        chk("spaced count", int'(count), 3);
        chk("spaced dir", int'(dir), 1);
        chk("spaced seg", int'(seg), int'(7'b1001111));

        // Single pulse: active high for exactly 8 cycles.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("idle1 k%0d active", k), int'(active), (k < 8) ? 1 : 0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Second pulse 6 cycles later extends the window to 8 past it.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("idle2 k%0d active", k), int'(active), (k < 14) ? 1 : 0);
            cyc(1'b0, 1'b1, (k + 1 == 6), 1'b0);
        end

        // ena low for 3 cycles inside the window stretches it by 3.
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("idle3 k%0d active", k), int'(active), (k < 11) ? 1 : 0);
            cyc(1'b0, !((k + 1 >= 2) && (k + 1 <= 4)), 1'b0, 1'b0);
        end

        // Simultaneous steps at count 5 leave count, dir and active alone.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("both pre count", int'(count), 5);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("both count", int'(count), 5);
        chk("both dir", int'(dir), 1);
        chk("both err", int'(err_pulse), 1);
        chk("both active", int'(active), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("both err drop", int'(err_pulse), 0);

        // Reset coincident with a cw step at count 7.
        do_reset();
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst pre count", int'(count), 7);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst count", int'(count), 0);
        chk("rst active", int'(active), 0);
        chk("rst wrap", int'(wrap_pulse), 0);
        chk("rst dir", int'(dir), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
